// File: rtl/cursor_ctrl.sv
// Cursor controller: synchronizes and debounces 4 direction and 3 action buttons,
// steps a 64x64 wrap-around cursor on press and on auto-repeat while held.
module cursor_ctrl #(
  parameter int DEB_CYCLES    = 16,
  parameter int REPEAT_DELAY  = 2000,
  parameter int REPEAT_PERIOD = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [2:0] btn_act,
  output logic [5:0] out_x,
  output logic [5:0] out_y,
  output logic [2:0] out_button,
  output logic       moved
);

  localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  // Per-direction repeat state; rs_q is the observable FSM state for checkers.
  typedef enum logic [1:0] {RS_IDLE, RS_DELAY, RS_PERIOD} rep_state_t;

  // Bit order: 0 up, 1 down, 2 left, 3 right, 6:4 action buttons.
  logic [6:0]    raw;
  logic [6:0]    sync1, sync2, deb;
  logic [DW-1:0] deb_cnt [7];

  logic [3:0]    dir_prev;
  logic [3:0]    ok;
  logic [3:0]    step;
  rep_state_t    rs_q [4];
  rep_state_t    rs_d [4];
  logic [RW-1:0] rc_q [4];
  logic [RW-1:0] rc_d [4];
  logic [5:0]    x_next, y_next;

  assign raw = {btn_act, btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < 7; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 7; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A direction may only step while enabled and its opposing partner is released.
  assign ok[0] = enable & ~(deb[0] & deb[1]);
  assign ok[1] = ok[0];
  assign ok[2] = enable & ~(deb[2] & deb[3]);
  assign ok[3] = ok[2];

  always_comb begin
    for (int d = 0; d < 4; d++) begin
      rs_d[d] = rs_q[d];
      rc_d[d] = rc_q[d];
      step[d] = 1'b0;
      if (!ok[d] || !deb[d]) begin
        rs_d[d] = RS_IDLE;
        rc_d[d] = '0;
      end else if (!dir_prev[d]) begin
        step[d] = 1'b1;
        rs_d[d] = RS_DELAY;
        rc_d[d] = '0;
      end else begin
        unique case (rs_q[d])
          RS_DELAY: begin
            if (rc_q[d] == RW'(REPEAT_DELAY - 1)) begin
              step[d] = 1'b1;
              rs_d[d] = RS_PERIOD;
              rc_d[d] = '0;
            end else if (rc_q[d] != RW'(RMAX - 1)) begin
              rc_d[d] = rc_q[d] + 1'b1;
            end
          end
          RS_PERIOD: begin
            if (rc_q[d] == RW'(REPEAT_PERIOD - 1)) begin
              step[d] = 1'b1;
              rc_d[d] = '0;
            end else if (rc_q[d] != RW'(RMAX - 1)) begin
              rc_d[d] = rc_q[d] + 1'b1;
            end
          end
          default: rc_d[d] = '0;  // held across enable rise or conflict: wait for release
        endcase
      end
    end

    x_next = out_x;
    if (step[3])      x_next = out_x + 6'd1;
    else if (step[2]) x_next = out_x - 6'd1;
    y_next = out_y;
    if (step[1])      y_next = out_y + 6'd1;
    else if (step[0]) y_next = out_y - 6'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_x      <= 6'd32;
      out_y      <= 6'd32;
      out_button <= '0;
      moved      <= 1'b0;
      dir_prev   <= '0;
      for (int d = 0; d < 4; d++) begin
        rs_q[d] <= RS_IDLE;
        rc_q[d] <= '0;
      end
    end else begin
      out_x      <= x_next;
      out_y      <= y_next;
      out_button <= enable ? deb[6:4] : 3'b000;
      moved      <= |step;
      dir_prev   <= deb[3:0];
      for (int d = 0; d < 4; d++) begin
        rs_q[d] <= rs_d[d];
        rc_q[d] <= rc_d[d];
      end
    end
  end

endmodule
